outlier_merge: RTL and testbench

OUTLIER_MERGE -- requirements
Module: outlier_merge

---
 rtl/outlier_merge.sv | 181 ++++++++++++++++++
 tb/tb_outlier_merge.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outlier_merge.sv
// ----------------------------------------------------------------------------
// outlier_merge
//
// Purpose:
//   Joins three streams: a per-element outlier mask, the normal-path results
//   and the outlier-path results. Each element of the merged beat comes from
//   the outlier path when its mask bit is set and from the normal path
//   otherwise. Merged beats, with the popcount of their mask, go through a
//   2-entry output FIFO. A saturating counter accumulates the number of
//   outlier elements accepted since reset or the last clear.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   mask_in           per-element outlier flags (bit i -> element i)
//   mask_in_valid     mask beat valid
//   mask_in_ready     mask beat accepted
//   data_in_0         normal-path results, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_in_0_valid   normal-path beat valid
//   data_in_0_ready   normal-path beat accepted
//   data_in_1         outlier-path results, same layout
//   data_in_1_valid   outlier-path beat valid
//   data_in_1_ready   outlier-path beat accepted
//   data_out_0        merged beat at the FIFO head
//   outlier_count     mask popcount for the beat on data_out_0
//   data_out_0_valid  FIFO not empty
//   data_out_0_ready  downstream accepts the head beat
//   clear             synchronous pulse that zeroes total_outliers
//   total_outliers    saturating count of accepted outlier elements
// ----------------------------------------------------------------------------
module outlier_merge #(
    parameter int DATA_WIDTH  = 16,
    parameter int BLOCK_SIZE  = 4,
    parameter int TOTAL_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [BLOCK_SIZE-1:0]              mask_in,
    input  logic                               mask_in_valid,
    output logic                               mask_in_ready,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   data_in_0,
    input  logic                               data_in_0_valid,
    output logic                               data_in_0_ready,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   data_in_1,
    input  logic                               data_in_1_valid,
    output logic                               data_in_1_ready,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0]   data_out_0,
    output logic [$clog2(BLOCK_SIZE+1)-1:0]    outlier_count,
    output logic                               data_out_0_valid,
    input  logic                               data_out_0_ready,
    input  logic                               clear,
    output logic [TOTAL_WIDTH-1:0]             total_outliers
);

    localparam int BUS_WIDTH   = BLOCK_SIZE * DATA_WIDTH;
    localparam int COUNT_WIDTH = $clog2(BLOCK_SIZE + 1);
    // One spare bit above the wider operand so the saturation test never wraps.
    localparam int SUM_WIDTH   = ((TOTAL_WIDTH > COUNT_WIDTH) ? TOTAL_WIDTH : COUNT_WIDTH) + 1;

    logic [BUS_WIDTH-1:0]   buf_data  [2];
    logic [COUNT_WIDTH-1:0] buf_count [2];
    logic [1:0]             occupancy;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic                   accept_enable;

    logic                   all_valid;
    logic                   not_full;
    logic                   fire;
    logic                   pop;
    logic [BUS_WIDTH-1:0]   merged;
    logic [COUNT_WIDTH-1:0] mask_popcount;

    logic [TOTAL_WIDTH-1:0] total_base;
    logic [SUM_WIDTH-1:0]   total_sum;
    logic [SUM_WIDTH-1:0]   total_max_ext;
    logic [TOTAL_WIDTH-1:0] total_next;

    // accept_enable is low during reset and for the first cycle after release,
    // which keeps every ready low until the block has seen one clean edge.
    assign all_valid = mask_in_valid & data_in_0_valid & data_in_1_valid;
    // Fullness comes from registered occupancy only, so data_out_0_ready never
    // reaches an input ready combinationally.
    assign not_full  = (occupancy != 2'd2);
    assign fire      = accept_enable & all_valid & not_full;
    assign pop       = (occupancy != 2'd0) & data_out_0_ready;

    // The three readies are the same signal so no stream is consumed alone.
    assign mask_in_ready   = fire;
    assign data_in_0_ready = fire;
    assign data_in_1_ready = fire;

    assign data_out_0       = buf_data[rd_ptr];
    assign outlier_count    = buf_count[rd_ptr];
    assign data_out_0_valid = (occupancy != 2'd0);

    // Element-wise select between the two result paths, bits passed untouched.
    always_comb begin
        merged = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            merged[i*DATA_WIDTH +: DATA_WIDTH] = mask_in[i] ? data_in_1[i*DATA_WIDTH +: DATA_WIDTH]
                                                            : data_in_0[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Number of outlier elements in the incoming mask.
    always_comb begin
        mask_popcount = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            mask_popcount = mask_popcount + COUNT_WIDTH'(mask_in[i]);
        end
    end

    // Saturating accumulate; clear drops the old total but still adds a
    // coincident fire so that beat's outliers are not lost.
    always_comb begin
        total_base    = clear ? '0 : total_outliers;
        total_max_ext = SUM_WIDTH'({TOTAL_WIDTH{1'b1}});
        total_sum     = SUM_WIDTH'(total_base) + (fire ? SUM_WIDTH'(mask_popcount) : '0);
        if (total_sum > total_max_ext) begin
            total_next = {TOTAL_WIDTH{1'b1}};
        end else begin
            total_next = total_sum[TOTAL_WIDTH-1:0];
        end
    end

    // Gate that holds the readies low for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accept_enable <= 1'b0;
        end else begin
            accept_enable <= 1'b1;
        end
    end

    // Two-entry FIFO storage. Writing lands at wr_ptr, which differs from
    // rd_ptr whenever the FIFO is non-empty and a write is possible, so the
    // head stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i]  <= '0;
                buf_count[i] <= '0;
            end
        end else if (fire) begin
            buf_data[wr_ptr]  <= merged;
            buf_count[wr_ptr] <= mask_popcount;
        end
    end

    // Pointers wrap modulo 2; occupancy is unchanged on simultaneous push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({fire, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Running outlier total.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_outliers <= '0;
        end else begin
            total_outliers <= total_next;
        end
    end

endmodule

// File: tb/tb_outlier_merge.sv
// ----------------------------------------------------------------------------
// tb_outlier_merge
//
// Self-checking bench for outlier_merge (DATA_WIDTH=16, BLOCK_SIZE=4,
// TOTAL_WIDTH=4 so saturation is reachable). A scoreboard queue receives the
// expected merged beat whenever the bench's own model decides a fire happens,
// and its head is compared with the DUT output.
// ----------------------------------------------------------------------------
module tb_outlier_merge;

    localparam int DW  = 16;
    localparam int BS  = 4;
    localparam int TW  = 4;
    localparam int BUS = DW * BS;
    localparam int CW  = $clog2(BS + 1);
    localparam int TOTAL_MAX = (1 << TW) - 1;

    typedef struct {
        logic [BUS-1:0] data;
        logic [CW-1:0]  cnt;
    } beat_t;

    logic            clk;
    logic            rst;
    logic [BS-1:0]   mask_in;
    logic            mask_in_valid;
    logic            mask_in_ready;
    logic [BUS-1:0]  data_in_0;
    logic            data_in_0_valid;
    logic            data_in_0_ready;
    logic [BUS-1:0]  data_in_1;
    logic            data_in_1_valid;
    logic            data_in_1_ready;
    logic [BUS-1:0]  data_out_0;
    logic [CW-1:0]   outlier_count;
    logic            data_out_0_valid;
    logic            data_out_0_ready;
    logic            clear;
    logic [TW-1:0]   total_outliers;

    int    n_cmp;
    int    n_fail;
    beat_t sb[$];
    int    model_total;
    logic  model_running;

    outlier_merge #(
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS),
        .TOTAL_WIDTH(TW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mask_in         (mask_in),
        .mask_in_valid   (mask_in_valid),
        .mask_in_ready   (mask_in_ready),
        .data_in_0       (data_in_0),
        .data_in_0_valid (data_in_0_valid),
        .data_in_0_ready (data_in_0_ready),
        .data_in_1       (data_in_1),
        .data_in_1_valid (data_in_1_valid),
        .data_in_1_ready (data_in_1_ready),
        .data_out_0      (data_out_0),
        .outlier_count   (outlier_count),
        .data_out_0_valid(data_out_0_valid),
        .data_out_0_ready(data_out_0_ready),
        .clear           (clear),
        .total_outliers  (total_outliers)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference merge: element i from the outlier path when mask bit i is set.
    function automatic beat_t ref_merge(input logic [BS-1:0] m, input logic [BUS-1:0] d0,
                                        input logic [BUS-1:0] d1);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < BS; i++) begin
            if (m[i]) b.data[i*DW +: DW] = d1[i*DW +: DW];
            else      b.data[i*DW +: DW] = d0[i*DW +: DW];
        end
        b.cnt = CW'($countones(m));
        return b;
    endfunction

    function automatic logic model_ready();
        return model_running && mask_in_valid && data_in_0_valid && data_in_1_valid && (sb.size() < 2);
    endfunction

    task automatic reset_model();
        sb.delete();
        model_total   = 0;
        model_running = 1'b0;
    endtask

    // Advance one clock edge and update the model with what the edge does.
    task automatic tick();
        logic  fire;
        logic  pop;
        beat_t b;
        int    base;
        fire = model_ready();
        pop  = (sb.size() != 0) && data_out_0_ready;
        b    = ref_merge(mask_in, data_in_0, data_in_1);
        @(posedge clk);
        if (!rst) begin
            reset_model();
        end else begin
            if (pop) void'(sb.pop_front());
            if (fire) sb.push_back(b);
            base = clear ? 0 : model_total;
            if (fire) base = base + $countones(mask_in);
            model_total   = (base > TOTAL_MAX) ? TOTAL_MAX : base;
            model_running = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        mask_in_valid   = 1'b0;
        data_in_0_valid = 1'b0;
        data_in_1_valid = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic drive_beat(input logic [BS-1:0] m, input logic [BUS-1:0] d0, input logic [BUS-1:0] d1);
        mask_in         = m;
        data_in_0       = d0;
        data_in_1       = d1;
        mask_in_valid   = 1'b1;
        data_in_0_valid = 1'b1;
        data_in_1_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_beat(4'b1111, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        data_out_0_ready = 1'b1;
        clear = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({mask_in_ready, data_in_0_ready, data_in_1_ready} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL reset_readies got=%b exp=000", {mask_in_ready, data_in_0_ready, data_in_1_ready});
        end
        n_cmp++;
        if (data_out_0_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_valid got=%b exp=0", data_out_0_valid);
        end
        n_cmp++;
        if (data_out_0 !== '0 || outlier_count !== '0) begin
            n_fail++; $display("[TB] FAIL reset_data got=%h/%0d exp=0/0", data_out_0, outlier_count);
        end
        n_cmp++;
        if (total_outliers !== '0) begin
            n_fail++; $display("[TB] FAIL reset_total got=%0d exp=0", total_outliers);
        end
        // Release between edges; the remainder of this cycle must not accept.
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({mask_in_ready, data_in_0_ready, data_in_1_ready} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL reset_first_cycle got=%b exp=000", {mask_in_ready, data_in_0_ready, data_in_1_ready});
        end
        tick();
        n_cmp++;
        if ({mask_in_ready, data_in_0_ready, data_in_1_ready} !== 3'b111) begin
            n_fail++; $display("[TB] FAIL reset_ready_after got=%b exp=111", {mask_in_ready, data_in_0_ready, data_in_1_ready});
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_basic_merge();
        data_out_0_ready = 1'b1;
        drive_beat(4'b0101, {16'd4, 16'd3, 16'd2, 16'd1}, {16'h7000, 16'h6000, 16'h5000, 16'h4000});
        #1;
        n_cmp++;
        if (mask_in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL basic_ready got=%b exp=1", mask_in_ready);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (data_out_0_valid !== 1'b1 || data_out_0 !== {16'd4, 16'h6000, 16'd2, 16'h4000}) begin
            n_fail++; $display("[TB] FAIL basic_data got=%b/%h exp=1/0004600000024000", data_out_0_valid, data_out_0);
        end
        n_cmp++;
        if (outlier_count !== 3'd2) begin
            n_fail++; $display("[TB] FAIL basic_count got=%0d exp=2", outlier_count);
        end
        n_cmp++;
        if (total_outliers !== 4'd2) begin
            n_fail++; $display("[TB] FAIL basic_total got=%0d exp=2", total_outliers);
        end
        tick();
        n_cmp++;
        if (data_out_0_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL basic_drain got=%b exp=0", data_out_0_valid);
        end
    endtask

    task automatic test_join_stall();
        beat_t exp;
        data_out_0_ready = 1'b1;
        drive_beat(4'b1001, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1234_5678_9ABC_DEF0);
        data_in_1_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({mask_in_ready, data_in_0_ready, data_in_1_ready, data_out_0_valid} !== 4'b0000) begin
                n_fail++; $display("[TB] FAIL stall_cycle%0d got=%b exp=0000", c,
                                   {mask_in_ready, data_in_0_ready, data_in_1_ready, data_out_0_valid});
            end
            tick();
        end
        data_in_1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({mask_in_ready, data_in_0_ready, data_in_1_ready} !== 3'b111) begin
            n_fail++; $display("[TB] FAIL stall_release got=%b exp=111", {mask_in_ready, data_in_0_ready, data_in_1_ready});
        end
        tick();
        idle_inputs();
        exp = ref_merge(4'b1001, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1234_5678_9ABC_DEF0);
        #1;
        n_cmp++;
        if (data_out_0_valid !== 1'b1 || data_out_0 !== exp.data || outlier_count !== exp.cnt) begin
            n_fail++; $display("[TB] FAIL stall_output got=%b/%h/%0d exp=1/%h/%0d", data_out_0_valid,
                               data_out_0, outlier_count, exp.data, exp.cnt);
        end
        tick();
        n_cmp++;
        if (data_out_0_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL stall_single_beat got=%b exp=0", data_out_0_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [BUS-1:0] d0 [3];
        logic [BUS-1:0] d1 [3];
        logic [BS-1:0]  m  [3];
        beat_t          exp [3];
        for (int k = 0; k < 3; k++) begin
            d0[k]  = {4{16'h0100 + 16'(k)}};
            d1[k]  = {4{16'hF000 + 16'(k)}};
            m[k]   = 4'(k + 3);
            exp[k] = ref_merge(m[k], d0[k], d1[k]);
        end
        data_out_0_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_beat(m[k], d0[k], d1[k]);
            #1;
            n_cmp++;
            if (mask_in_ready !== 1'b1) begin
                n_fail++; $display("[TB] FAIL bp_accept%0d got=%b exp=1", k, mask_in_ready);
            end
            tick();
        end
        drive_beat(m[2], d0[2], d1[2]);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if ({mask_in_ready, data_in_0_ready, data_in_1_ready} !== 3'b000) begin
                n_fail++; $display("[TB] FAIL bp_full_ready got=%b exp=000", {mask_in_ready, data_in_0_ready, data_in_1_ready});
            end
            n_cmp++;
            if (data_out_0_valid !== 1'b1 || data_out_0 !== exp[0].data || outlier_count !== exp[0].cnt) begin
                n_fail++; $display("[TB] FAIL bp_hold got=%h/%0d exp=%h/%0d", data_out_0, outlier_count, exp[0].data, exp[0].cnt);
            end
            tick();
        end
        // Ready released while full: input ready must still be low this cycle.
        data_out_0_ready = 1'b1;
        #1;
        n_cmp++;
        if (mask_in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp_no_comb_path got=%b exp=0", mask_in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (data_out_0_valid !== 1'b1 || data_out_0 !== exp[k].data || outlier_count !== exp[k].cnt) begin
                n_fail++; $display("[TB] FAIL bp_order%0d got=%b/%h/%0d exp=1/%h/%0d", k, data_out_0_valid,
                                   data_out_0, outlier_count, exp[k].data, exp[k].cnt);
            end
            tick();
            if (sb.size() == 0 || k == 1) idle_inputs();
        end
        #1;
        n_cmp++;
        if (data_out_0_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++; $display("[TB] FAIL bp_no_dup got=%b exp=0", data_out_0_valid);
        end
        idle_inputs();
    endtask

    task automatic test_saturation_clear();
        logic [TW-1:0] exp_tot [5];
        beat_t         exp;
        exp_tot[0] = 4'd4; exp_tot[1] = 4'd8; exp_tot[2] = 4'd12; exp_tot[3] = 4'd15; exp_tot[4] = 4'd15;
        data_out_0_ready = 1'b1;
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (total_outliers !== 4'd0) begin
            n_fail++; $display("[TB] FAIL sat_clear_idle got=%0d exp=0", total_outliers);
        end
        for (int k = 0; k < 5; k++) begin
            drive_beat(4'b1111, 64'h0, {4{16'h7FFF}});
            tick();
            n_cmp++;
            if (total_outliers !== exp_tot[k]) begin
                n_fail++; $display("[TB] FAIL sat_step%0d got=%0d exp=%0d", k, total_outliers, exp_tot[k]);
            end
        end
        drive_beat(4'b0011, 64'h0102_0304_0506_0708, 64'h8070_6050_4030_2010);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle_inputs();
        n_cmp++;
        if (total_outliers !== 4'd2) begin
            n_fail++; $display("[TB] FAIL sat_clear_fire got=%0d exp=2", total_outliers);
        end
        exp = ref_merge(4'b0011, 64'h0102_0304_0506_0708, 64'h8070_6050_4030_2010);
        n_cmp++;
        if (data_out_0 !== exp.data || outlier_count !== 3'd2) begin
            n_fail++; $display("[TB] FAIL sat_clear_data got=%h/%0d exp=%h/2", data_out_0, outlier_count, exp.data);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        beat_t exp;
        data_out_0_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_beat(4'b1010, {4{16'h0033 + 16'(k)}}, {4{16'h0C00 + 16'(k)}});
            tick();
        end
        #1;
        n_cmp++;
        if (data_out_0_valid !== 1'b1 || sb.size() != 2) begin
            n_fail++; $display("[TB] FAIL mid_fill got=%b exp=1", data_out_0_valid);
        end
        rst = 1'b0;
        reset_model();
        #1;
        n_cmp++;
        if (data_out_0_valid !== 1'b0 || total_outliers !== '0 || data_out_0 !== '0) begin
            n_fail++; $display("[TB] FAIL mid_async got=%b/%0d/%h exp=0/0/0", data_out_0_valid, total_outliers, data_out_0);
        end
        n_cmp++;
        if ({mask_in_ready, data_in_0_ready, data_in_1_ready} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL mid_readies got=%b exp=000", {mask_in_ready, data_in_0_ready, data_in_1_ready});
        end
        tick();
        #2 rst = 1'b1;
        data_out_0_ready = 1'b1;
        #1;
        n_cmp++;
        if (mask_in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_first_cycle got=%b exp=0", mask_in_ready);
        end
        tick();
        drive_beat(4'b0110, 64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        idle_inputs();
        exp = ref_merge(4'b0110, 64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD);
        #1;
        n_cmp++;
        if (data_out_0_valid !== 1'b1 || data_out_0 !== exp.data || outlier_count !== exp.cnt || total_outliers !== 4'd2) begin
            n_fail++; $display("[TB] FAIL mid_new_beat got=%b/%h/%0d/%0d exp=1/%h/%0d/2", data_out_0_valid,
                               data_out_0, outlier_count, total_outliers, exp.data, exp.cnt);
        end
        tick();
    endtask

    task automatic test_random();
        int   beats;
        logic exp_rdy;
        beats = 0;
        for (int cyc = 0; cyc < 60000 && beats < 10000; cyc++) begin
            mask_in          = BS'($urandom);
            data_in_0        = {$urandom, $urandom};
            data_in_1        = {$urandom, $urandom};
            mask_in_valid    = ($urandom_range(3) != 0);
            data_in_0_valid  = ($urandom_range(3) != 0);
            data_in_1_valid  = ($urandom_range(3) != 0);
            data_out_0_ready = ($urandom_range(3) != 0);
            clear            = ($urandom_range(15) == 0);
            #1;
            exp_rdy = model_ready();
            n_cmp++;
            if ({mask_in_ready, data_in_0_ready, data_in_1_ready} !== {3{exp_rdy}}) begin
                n_fail++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc,
                                   {mask_in_ready, data_in_0_ready, data_in_1_ready}, {3{exp_rdy}});
            end
            n_cmp++;
            if (data_out_0_valid !== (sb.size() != 0)) begin
                n_fail++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, data_out_0_valid, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                n_cmp++;
                if (data_out_0 !== sb[0].data || outlier_count !== sb[0].cnt) begin
                    n_fail++; $display("[TB] FAIL rnd_data cyc=%0d got=%h/%0d exp=%h/%0d", cyc,
                                       data_out_0, outlier_count, sb[0].data, sb[0].cnt);
                end
            end
            n_cmp++;
            if (total_outliers !== TW'(model_total)) begin
                n_fail++; $display("[TB] FAIL rnd_total cyc=%0d got=%0d exp=%0d", cyc, total_outliers, model_total);
            end
            if (exp_rdy) beats++;
            tick();
        end
        n_cmp++;
        if (beats < 10000) begin
            n_fail++; $display("[TB] FAIL rnd_budget got=%0d exp=10000", beats);
        end
        idle_inputs();
        data_out_0_ready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (data_out_0_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++; $display("[TB] FAIL rnd_drain got=%b exp=0", data_out_0_valid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        mask_in = '0;
        data_in_0 = '0;
        data_in_1 = '0;
        data_out_0_ready = 1'b0;
        idle_inputs();
        reset_model();
        test_reset();
        test_basic_merge();
        test_join_stall();
        test_backpressure();
        test_saturation_clear();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
